// File: rtl/bcd_sqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_sqrt_pkg
// Description : Shared types, constants and helpers for the sequential BCD
//               square-root engine (state encoding, result sizing, BCD
//               shift-add-3 step).
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_sqrt_pkg;

    // Engine phases, in the order an operand flows through them
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_B2B    = 3'd1,
        ST_SQRT   = 3'd2,
        ST_FIX    = 3'd3,
        ST_DABBLE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Largest legal value of a BCD nibble
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Result digit count: half the operand digits (rounded up) plus one
    // spare digit so a rounded-up root such as 999 -> 1000 still fits.
    function automatic int out_digits_f(input int in_digits);
        return (in_digits + 1) / 2 + 1;
    endfunction

    // One double-dabble correction: digits of 5 or more get +3 before the
    // shift so that the doubled value carries correctly into the next digit.
    function automatic logic [3:0] bcd_add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage : bcd_sqrt_pkg
`default_nettype wire

// File: rtl/bcd_sqrt_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_sqrt_seq_if
// Description : Operand/result handshake bundle for bcd_sqrt_seq. The
//               master side supplies operands and consumes results; the
//               slave side is the engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_sqrt_seq_if
    import bcd_sqrt_pkg::*;
#(
    parameter int IN_DIGITS = 6
);
    localparam int OUT_DIGITS = out_digits_f(IN_DIGITS);

    logic                      in_valid;
    logic                      in_ready;
    logic [4*IN_DIGITS-1:0]    in_bcd;
    logic                      out_valid;
    logic                      out_ready;
    logic [4*OUT_DIGITS-1:0]   out_bcd;
    logic                      out_err;
    logic                      busy;

    modport master (
        output in_valid,
        input  in_ready,
        output in_bcd,
        input  out_valid,
        output out_ready,
        input  out_bcd,
        input  out_err,
        input  busy
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_bcd,
        output out_valid,
        input  out_ready,
        output out_bcd,
        output out_err,
        output busy
    );

endinterface : bcd_sqrt_seq_if
`default_nettype wire

// File: rtl/bcd_dabble_ser.sv
`default_nettype none
// ============================================================================
// Module      : bcd_dabble_ser
// Description : Serial binary-to-packed-BCD converter (double dabble). A
//               start pulse loads the binary value; Q_W following cycles
//               each shift one bit in, MSB first. done is high during the
//               cycle that performs the final shift, so bcd is complete on
//               the edge that ends that cycle and is then held.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_dabble_ser
    import bcd_sqrt_pkg::*;
#(
    parameter int Q_W        = 12,
    parameter int OUT_DIGITS = 4
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    start,
    input  wire logic [Q_W-1:0]          bin,
    output logic                         done,
    output logic [4*OUT_DIGITS-1:0]      bcd
);

    localparam int BCD_W = 4 * OUT_DIGITS;
    localparam int CNT_W = $clog2(Q_W + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(Q_W - 1);

    logic [Q_W-1:0]   r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;
    logic [BCD_W-1:0] w_adj;

    // Per-digit add-3 correction ahead of each shift
    generate
        for (genvar i = 0; i < OUT_DIGITS; i++) begin : g_adj
            assign w_adj[4*i +: 4] = bcd_add3(r_bcd[4*i +: 4]);
        end
    endgenerate

    // Load on start, then shift one binary bit into the BCD digits per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_bin    <= bin;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[Q_W-1]};
            r_bin <= {r_bin[Q_W-2:0], 1'b0};
            if (r_cnt == C_LAST) begin
                r_active <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign done = r_active && (r_cnt == C_LAST);
    assign bcd  = r_bcd;

endmodule : bcd_dabble_ser
`default_nettype wire

// File: rtl/bcd_sqrt_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_sqrt_seq
// Description : Sequential BCD integer square root. Operand is converted
//               BCD->binary one digit per cycle, the root is found one bit
//               per cycle by restoring shift/subtract, an optional rounding
//               step follows, and the root is converted back to packed BCD
//               serially. Latency from accept to out_valid is
//               IN_DIGITS + 2*Q_W + 1 edges.
//               Optional feature macro: BCD_SQRT_ROUND_EN (round half-up of
//               the real root instead of floor).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_sqrt_seq
    import bcd_sqrt_pkg::*;
#(
    parameter int IN_DIGITS = 6
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    bcd_sqrt_seq_if.slave   bus
);

    localparam int BIN_W      = 4 * IN_DIGITS;
    localparam int Q_W        = BIN_W / 2;
    localparam int OUT_DIGITS = out_digits_f(IN_DIGITS);
    localparam int RW         = Q_W + 2;
    localparam int CNT_W      = $clog2(Q_W + 1);

    localparam logic [CNT_W-1:0] C_B2B_LAST  = CNT_W'(IN_DIGITS - 1);
    localparam logic [CNT_W-1:0] C_SQRT_LAST = CNT_W'(Q_W - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [BIN_W-1:0]          r_opnd;
    logic [BIN_W-1:0]          r_acc;
    logic [RW-1:0]             r_rem;
    logic [Q_W-1:0]            r_q;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_err;

    logic [3:0]                w_nib;
    logic                      w_nib_bad;
    logic [3:0]                w_digit;
    logic [BIN_W-1:0]          w_acc_x10;
    logic [RW-1:0]             w_rem_sh;
    logic [RW:0]               w_diff;
    logic [Q_W-1:0]            w_q_fix;
    logic                      w_dab_start;
    logic                      w_dab_done;
    logic [4*OUT_DIGITS-1:0]   w_dab_bcd;

    // Digit entering the binary accumulator; illegal nibbles count as zero
    assign w_nib     = r_opnd[BIN_W-1 -: 4];
    assign w_nib_bad = (w_nib > BCD_MAX_DIGIT);
    assign w_digit   = w_nib_bad ? 4'd0 : w_nib;
    assign w_acc_x10 = (r_acc << 3) + (r_acc << 1);

    // Restoring step: bring down two operand bits, try subtracting 4q+1.
    // The remainder never exceeds 2q, so its top two bits are always zero
    // before the shift and dropping them loses nothing.
    assign w_rem_sh = {r_rem[RW-3:0], r_acc[BIN_W-1 -: 2]};
    assign w_diff   = {1'b0, w_rem_sh} - {1'b0, r_q, 2'b01};

`ifdef BCD_SQRT_ROUND_EN
    // rem > q means n > q^2 + q, i.e. sqrt(n) is at least q + 0.5
    assign w_q_fix = (r_rem > RW'(r_q)) ? r_q + 1'b1 : r_q;
`else
    assign w_q_fix = r_q;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_dab_start   = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    w_state_nxt = ST_B2B;
                end
            end
            ST_B2B: begin
                if (r_cnt == C_B2B_LAST) begin
                    w_state_nxt = ST_SQRT;
                end
            end
            ST_SQRT: begin
                if (r_cnt == C_SQRT_LAST) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                w_dab_start = 1'b1;
                w_state_nxt = ST_DABBLE;
            end
            ST_DABBLE: begin
                if (w_dab_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture, BCD->binary accumulation and root iteration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opnd <= '0;
            r_acc  <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_opnd <= bus.in_bcd;
                        r_acc  <= '0;
                        r_rem  <= '0;
                        r_q    <= '0;
                        r_cnt  <= '0;
                        r_err  <= 1'b0;
                    end
                end
                ST_B2B: begin
                    r_acc  <= w_acc_x10 + BIN_W'(w_digit);
                    r_opnd <= {r_opnd[BIN_W-5:0], 4'd0};
                    if (w_nib_bad) begin
                        r_err <= 1'b1;
                    end
                    r_cnt <= (r_cnt == C_B2B_LAST) ? '0 : r_cnt + 1'b1;
                end
                ST_SQRT: begin
                    r_rem <= w_diff[RW] ? w_rem_sh : w_diff[RW-1:0];
                    r_q   <= {r_q[Q_W-2:0], ~w_diff[RW]};
                    r_acc <= {r_acc[BIN_W-3:0], 2'b00};
                    r_cnt <= (r_cnt == C_SQRT_LAST) ? '0 : r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    bcd_dabble_ser #(
        .Q_W        (Q_W),
        .OUT_DIGITS (OUT_DIGITS)
    ) u_dabble (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_dab_start),
        .bin   (w_q_fix),
        .done  (w_dab_done),
        .bcd   (w_dab_bcd)
    );

    // A flagged operand reports zero so no garbage root reaches the display
    assign bus.out_bcd = r_err ? '0 : w_dab_bcd;
    assign bus.out_err = r_err;

endmodule : bcd_sqrt_seq
`default_nettype wire

// File: tb/tb_bcd_sqrt_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_sqrt_seq
// Description : Self-checking bench for bcd_sqrt_seq (IN_DIGITS = 6). A
//               vector table covers the main function; hand-written
//               sequences cover result stalling and mid-operation reset.
//               Expected roots follow BCD_SQRT_ROUND_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_sqrt_seq;

    localparam int IN_DIGITS = 6;
    localparam int LATENCY   = 31;
    localparam int TIMEOUT   = 100;

    typedef struct {
        logic [23:0] in_bcd;
        logic [15:0] exp_bcd;
        logic        exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    bcd_sqrt_seq_if #(.IN_DIGITS(IN_DIGITS)) bus ();

    bcd_sqrt_seq #(.IN_DIGITS(IN_DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one operand, then count edges until out_valid (bounded)
    task automatic launch(input logic [23:0] v, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bcd   = v;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    vec_t vecs [11];

    initial begin
        int            lat;
        logic [15:0]   held;

        vecs[0]  = '{24'h000144, 16'h0012, 1'b0};
`ifdef BCD_SQRT_ROUND_EN
        vecs[1]  = '{24'h999999, 16'h1000, 1'b0};
        vecs[2]  = '{24'h000007, 16'h0003, 1'b0};
        vecs[4]  = '{24'h000003, 16'h0002, 1'b0};
        vecs[5]  = '{24'h000099, 16'h0010, 1'b0};
`else
        vecs[1]  = '{24'h999999, 16'h0999, 1'b0};
        vecs[2]  = '{24'h000007, 16'h0002, 1'b0};
        vecs[4]  = '{24'h000003, 16'h0001, 1'b0};
        vecs[5]  = '{24'h000099, 16'h0009, 1'b0};
`endif
        vecs[3]  = '{24'h000006, 16'h0002, 1'b0};
        vecs[6]  = '{24'h00A000, 16'h0000, 1'b1};
        vecs[7]  = '{24'h000000, 16'h0000, 1'b0};
        vecs[8]  = '{24'h012345, 16'h0111, 1'b0};
        vecs[9]  = '{24'h000100, 16'h0010, 1'b0};
        vecs[10] = '{24'h000002, 16'h0001, 1'b0};

        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bcd   = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready",  32'(bus.in_ready),  32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset busy",      32'(bus.busy),      32'd0);
        check("reset out_bcd",   32'(bus.out_bcd),   32'd0);
        check("reset out_err",   32'(bus.out_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // out_ready high while idle must not disturb anything
        repeat (3) @(posedge clk);
        #1;
        check("idle out_valid", 32'(bus.out_valid), 32'd0);

        // Table-driven vectors, out_ready held high
        for (int i = 0; i < 11; i++) begin
            launch(vecs[i].in_bcd, lat);
            check($sformatf("v%0d latency", i), 32'(lat),          32'(LATENCY));
            check($sformatf("v%0d out_bcd", i), 32'(bus.out_bcd),  32'(vecs[i].exp_bcd));
            check($sformatf("v%0d out_err", i), 32'(bus.out_err),  32'(vecs[i].exp_err));
            check($sformatf("v%0d in_ready in DONE", i), 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid drop", i), 32'(bus.out_valid), 32'd0);
            check($sformatf("v%0d in_ready back", i),  32'(bus.in_ready),  32'd1);
        end

        // Stall in DONE for 10 cycles while in_valid pulses
        @(negedge clk);
        bus.out_ready = 1'b0;
        launch(24'h000049, lat);
        check("stall latency", 32'(lat), 32'(LATENCY));
        check("stall out_bcd", 32'(bus.out_bcd), 32'h0007);
        held = bus.out_bcd;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.in_valid = k[0];
            bus.in_bcd   = 24'h000016;
            @(posedge clk);
            #1;
            check($sformatf("stall%0d out_bcd", k),   32'(bus.out_bcd),   32'(held));
            check($sformatf("stall%0d in_ready", k),  32'(bus.in_ready),  32'd0);
            check($sformatf("stall%0d out_valid", k), 32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall release out_valid", 32'(bus.out_valid), 32'd0);
        check("stall release in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;
        check("stall pulses ignored busy", 32'(bus.busy), 32'd0);

        // Reset during SQRT aborts the operation
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bcd   = 24'h999999;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst busy",      32'(bus.busy),      32'd0);
        check("midrst out_bcd",   32'(bus.out_bcd),   32'd0);
        check("midrst out_err",   32'(bus.out_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (bus.out_valid) seen++;
            end
            check("midrst no out_valid", 32'(seen), 32'd0);
        end
        launch(24'h000081, lat);
        check("after rst latency", 32'(lat),         32'(LATENCY));
        check("after rst out_bcd", 32'(bus.out_bcd), 32'h0009);
        check("after rst out_err", 32'(bus.out_err), 32'd0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bcd_sqrt_seq
`default_nettype wire
